mem_bist_initiator: RTL and testbench



---
 rtl/mem_bist_pkg.sv | 21 ++
 rtl/mem_bist_initiator.sv | 197 +++++++++++++++++++
 tb/tb_mem_bist_initiator.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the memory BIST bus initiator.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WGAP,
    READ,
    RGAP,
    DONE
  } bist_state_e;

  localparam logic [3:0] WSTRB_WORD = 4'hF;
  localparam logic [3:0] WSTRB_READ = 4'h0;

  // Address-derived test pattern.
  function automatic logic [31:0] pattern(input logic [31:0] a, input logic [31:0] seed);
    return a ^ seed;
  endfunction

endpackage

// File: rtl/mem_bist_initiator.sv
// PicoRV32-native-bus initiator: writes a pattern over a word range, reads it back,
// and reports pass/fail, first mismatch, or a ready timeout.
module mem_bist_initiator
  import mem_bist_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [31:0]       err_addr,
  output logic [31:0]       err_expected,
  output logic [31:0]       err_actual,
  output logic              mem_valid,
  output logic              mem_instr,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output bist_state_e       dbg_state
);

  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  // Handshake: a transfer completes on the rising edge where mem_valid && mem_ready.
  // While mem_valid is high, mem_addr/mem_wdata/mem_wstrb do not change; mem_ready
  // while mem_valid is low is ignored.

  bist_state_e       state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d, count_q, count_d;
  logic [31:0]       base_q, base_d, seed_q, seed_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              valid_d, busy_d, done_d, pass_d, timeout_d;
  logic [31:0]       addr_d, wdata_d, err_addr_d, err_exp_d, err_act_d;
  logic [3:0]        wstrb_d;
  logic [31:0]       start_addr, next_addr, cur_pattern;
  logic              last_word;

  assign mem_instr   = 1'b0;
  assign dbg_state   = state_q;
  assign start_addr  = base_addr & 32'hFFFF_FFFC;
  assign next_addr   = mem_addr + 32'd4;
  assign cur_pattern = pattern(mem_addr, seed_q);
  assign last_word   = (idx_q == count_q - CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    base_d     = base_q;
    seed_d     = seed_q;
    wait_d     = wait_q;
    valid_d    = mem_valid;
    addr_d     = mem_addr;
    wdata_d    = mem_wdata;
    wstrb_d    = mem_wstrb;
    pass_d     = pass;
    timeout_d  = timeout;
    err_addr_d = err_addr;
    err_exp_d  = err_expected;
    err_act_d  = err_actual;

    case (state_q)
      IDLE: begin
        if (start) begin
          count_d    = word_count;
          base_d     = start_addr;
          seed_d     = seed;
          idx_d      = '0;
          wait_d     = '0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          err_addr_d = '0;
          err_exp_d  = '0;
          err_act_d  = '0;
          if (word_count == '0) begin
            state_d = DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = WRITE;
            valid_d = 1'b1;
            addr_d  = start_addr;
            wdata_d = pattern(start_addr, seed);
            wstrb_d = WSTRB_WORD;
          end
        end
      end
      WRITE, READ: begin
        if (mem_ready) begin
          valid_d = 1'b0;
          if (state_q == WRITE) begin
            state_d = WGAP;
          end else if (mem_rdata != cur_pattern) begin
            state_d    = DONE;
            err_addr_d = mem_addr;
            err_exp_d  = cur_pattern;
            err_act_d  = mem_rdata;
          end else if (last_word) begin
            state_d = DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = RGAP;
          end
        end else if (wait_q == WAIT_LAST) begin
          // Responder stuck: abandon the transfer and report where it hung.
          valid_d    = 1'b0;
          state_d    = DONE;
          timeout_d  = 1'b1;
          err_addr_d = mem_addr;
          err_exp_d  = cur_pattern;
          err_act_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      WGAP: begin
        valid_d = 1'b1;
        wait_d  = '0;
        if (last_word) begin
          state_d = READ;
          idx_d   = '0;
          addr_d  = base_q;
          wdata_d = '0;
          wstrb_d = WSTRB_READ;
        end else begin
          state_d = WRITE;
          idx_d   = idx_q + CNT_W'(1);
          addr_d  = next_addr;
          wdata_d = pattern(next_addr, seed_q);
        end
      end
      RGAP: begin
        state_d = READ;
        valid_d = 1'b1;
        wait_d  = '0;
        idx_d   = idx_q + CNT_W'(1);
        addr_d  = next_addr;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      count_q      <= '0;
      base_q       <= '0;
      seed_q       <= '0;
      wait_q       <= '0;
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      err_addr     <= '0;
      err_expected <= '0;
      err_actual   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      base_q       <= base_d;
      seed_q       <= seed_d;
      wait_q       <= wait_d;
      mem_valid    <= valid_d;
      mem_addr     <= addr_d;
      mem_wdata    <= wdata_d;
      mem_wstrb    <= wstrb_d;
      busy         <= busy_d;
      done         <= done_d;
      pass         <= pass_d;
      timeout      <= timeout_d;
      err_addr     <= err_addr_d;
      err_expected <= err_exp_d;
      err_actual   <= err_act_d;
    end
  end

endmodule

// File: tb/tb_mem_bist_initiator.sv
// Randomized bench for mem_bist_initiator: a responding RAM model, a transaction
// and result scoreboard fed by a behavioural model, and directed corner cases.
module tb_mem_bist_initiator;
  import mem_bist_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;

  logic              clk, reset, start;
  logic [31:0]       base_addr, seed;
  logic [CNT_W-1:0]  word_count;
  logic              busy, done, pass, timeout;
  logic [31:0]       err_addr, err_expected, err_actual;
  logic              mem_valid, mem_instr, mem_ready;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata;
  logic [3:0]        mem_wstrb;
  bist_state_e       dbg_state;

  mem_bist_initiator #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_addr(err_addr), .err_expected(err_expected),
    .err_actual(err_actual), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [64:0] exp_q[$];   // {is_write, addr, wdata}
  logic [97:0] res_q[$];   // {pass, timeout, err_addr, err_expected, err_actual}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- responder RAM ----------------
  int          max_wait = 0;
  bit          never_ready = 1'b0;
  bit          fault_en = 1'b0;
  logic [31:0] fault_addr = '0;
  int          wait_left = -1;
  logic [31:0] ram [logic [31:0]];

  function automatic logic [31:0] read_word(input logic [31:0] a);
    logic [31:0] v;
    v = ram.exists(a) ? ram[a] : 32'hDEAD_BEEF;
    if (fault_en && a == fault_addr) v[3] = 1'b0;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!mem_valid || reset) begin
      mem_ready = 1'b0;
      wait_left = -1;
    end else if (!mem_ready && !never_ready) begin
      if (wait_left < 0) wait_left = $urandom_range(0, max_wait);
      if (wait_left == 0) begin
        mem_ready = 1'b1;
        mem_rdata = read_word(mem_addr);
      end else begin
        wait_left--;
      end
    end
  end

  always @(posedge clk) begin
    if (!reset && mem_valid && mem_ready && mem_wstrb == 4'hF) ram[mem_addr] = mem_wdata;
  end

  // ---------------- monitor ----------------
  bit          prev_wait = 1'b0, prev_hs = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_wstrb;

  always @(negedge clk) begin
    logic [64:0] e;
    logic [97:0] r;
    #1;
    if (reset) begin
      prev_wait = 1'b0;
      prev_hs   = 1'b0;
    end else begin
      if (prev_wait && mem_valid) begin
        check("hold_addr", mem_addr, prev_addr);
        check("hold_wdata", mem_wdata, prev_wdata);
        check("hold_wstrb", 32'(mem_wstrb), 32'(prev_wstrb));
      end
      if (prev_hs) check("gap_after_transfer", 32'(mem_valid), 32'd0);
      if (mem_valid) check("mem_instr", 32'(mem_instr), 32'd0);
      if (mem_valid && mem_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_transfer_addr", mem_addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("txn_addr", mem_addr, e[63:32]);
          check("txn_wstrb", 32'(mem_wstrb), e[64] ? 32'hF : 32'h0);
          if (e[64]) check("txn_wdata", mem_wdata, e[31:0]);
        end
      end
      if (done) begin
        if (res_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          r = res_q.pop_front();
          check("res_pass", 32'(pass), 32'(r[97]));
          check("res_timeout", 32'(timeout), 32'(r[96]));
          check("res_err_addr", err_addr, r[95:64]);
          check("res_err_expected", err_expected, r[63:32]);
          check("res_err_actual", err_actual, r[31:0]);
        end
      end
      prev_wait  = mem_valid && !mem_ready;
      prev_hs    = mem_valid && mem_ready;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      prev_wstrb = mem_wstrb;
    end
  end

  // ---------------- reference model ----------------
  task automatic push_model(input logic [31:0] base, input int n, input logic [31:0] sd,
                            input bit nr, input bit fe, input logic [31:0] fa);
    logic [31:0] a0, a, e, act;
    a0 = base & 32'hFFFF_FFFC;
    if (n == 0) begin
      res_q.push_back({1'b1, 1'b0, 96'h0});
      return;
    end
    if (nr) begin
      res_q.push_back({1'b0, 1'b1, a0, a0 ^ sd, 32'h0});
      return;
    end
    for (int i = 0; i < n; i++) begin
      a = a0 + 32'(4 * i);
      exp_q.push_back({1'b1, a, a ^ sd});
    end
    for (int i = 0; i < n; i++) begin
      a   = a0 + 32'(4 * i);
      e   = a ^ sd;
      act = e;
      if (fe && a == fa) act[3] = 1'b0;
      exp_q.push_back({1'b0, a, 32'h0});
      if (act != e) begin
        res_q.push_back({2'b00, a, e, act});
        return;
      end
    end
    res_q.push_back({2'b10, 96'h0});
  endtask

  // ---------------- driver ----------------
  task automatic run_test(input logic [31:0] base, input int n, input logic [31:0] sd,
                          input int mw, input bit nr, input bit fe, input logic [31:0] fa,
                          input bit poke, output int done_cyc, output int valid_cyc);
    int cyc;
    int extra;
    push_model(base, n, sd, nr, fe, fa);
    max_wait = mw; never_ready = nr; fault_en = fe; fault_addr = fa;
    @(negedge clk);
    base_addr = base; word_count = CNT_W'(n); seed = sd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    cyc = 1; done_cyc = -1; valid_cyc = 0;
    for (int k = 0; k < 20000 && done_cyc < 0; k++) begin
      if (cyc == 1) begin
        check("busy_cycle1", 32'(busy), 32'd1);
        check("valid_cycle1", 32'(mem_valid), (n != 0) ? 32'd1 : 32'd0);
      end
      if (mem_valid) valid_cyc++;
      if (done) begin
        done_cyc = cyc;
      end else begin
        start = poke && (cyc == 3);
        @(negedge clk);
        #2;
        cyc++;
      end
    end
    start = 1'b0;
    if (done_cyc < 0) begin
      check("done_within_budget", 32'd0, 32'd1);
    end else begin
      check("busy_at_done", 32'(busy), 32'd1);
      @(negedge clk);
      #2;
      check("busy_after_done", 32'(busy), 32'd0);
      extra = 0;
      repeat (8) begin
        @(negedge clk);
        #2;
        if (done || mem_valid) extra++;
      end
      check("quiet_after_done", 32'(extra), 32'd0);
    end
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("res_q_drained", 32'(res_q.size()), 32'd0);
    exp_q.delete();
    res_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dc, vc, n;
    logic [31:0] b, s, a0;
    bit fe;
    logic [31:0] fa;
    bit seen;

    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; seed = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;

    // Always-ready RAM, four words: done lands exactly in cycle 4N.
    run_test(32'h0, 4, 32'hA5A5_A5A5, 0, 1'b0, 1'b0, 32'h0, 1'b0, dc, vc);
    check("n4_done_cycle", 32'(dc), 32'd16);
    check("n4_ram_0", ram[32'h0], 32'hA5A5_A5A5);
    check("n4_ram_4", ram[32'h4], 32'hA5A5_A5A1);
    check("n4_ram_8", ram[32'h8], 32'hA5A5_A5AD);
    check("n4_ram_c", ram[32'hC], 32'hA5A5_A5A9);

    // Random wait states over 64 words.
    run_test(32'h100, 64, $urandom, 5, 1'b0, 1'b0, 32'h0, 1'b0, dc, vc);

    // Stuck-at-0 on bit 3 of word 0x108.
    run_test(32'h100, 8, 32'h0, 0, 1'b0, 1'b1, 32'h108, 1'b0, dc, vc);

    // Responder never ready: 16 valid cycles, done the cycle after.
    run_test(32'h200, 3, 32'h1234_5678, 0, 1'b1, 1'b0, 32'h0, 1'b0, dc, vc);
    check("to_done_cycle", 32'(dc), 32'd17);
    check("to_valid_cycles", 32'(vc), 32'd16);

    // Empty range: immediate pass with no bus activity.
    run_test(32'h300, 0, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 32'h0, 1'b0, dc, vc);
    check("n0_done_cycle", 32'(dc), 32'd1);
    check("n0_valid_cycles", 32'(vc), 32'd0);

    // Start pulse while busy must not restart the run.
    run_test(32'h400, 10, $urandom, 2, 1'b0, 1'b0, 32'h0, 1'b1, dc, vc);

    // Randomized runs; the first wraps past the top of the address space.
    for (int t = 0; t < 6; t++) begin
      b  = (t == 0) ? 32'hFFFF_FFF6 : ($urandom & 32'h0000_FFFF);
      n  = (t == 0) ? 5 : $urandom_range(1, 24);
      s  = $urandom;
      a0 = b & 32'hFFFF_FFFC;
      fe = ($urandom_range(0, 1) == 1);
      fa = a0 + 32'(4 * $urandom_range(0, n - 1));
      run_test(b, n, s, $urandom_range(0, 3), 1'b0, fe, fa, 1'b0, dc, vc);
    end

    // Reset asserted while a read is on the bus.
    push_model(32'h500, 4, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'h0);
    max_wait = 0; never_ready = 1'b0; fault_en = 1'b0;
    @(negedge clk);
    base_addr = 32'h500; word_count = CNT_W'(4); seed = 32'h0F0F_0F0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      #2;
      if (mem_valid && mem_wstrb == 4'h0) seen = 1'b1;
      else @(negedge clk);
    end
    check("reached_read", 32'(seen), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    #2;
    check("rstmid_mem_valid", 32'(mem_valid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_state", 32'(dbg_state), 32'(IDLE));
    exp_q.delete();
    res_q.delete();
    reset = 1'b0;
    run_test(32'h600, 2, $urandom, 1, 1'b0, 1'b0, 32'h0, 1'b0, dc, vc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
